// File: rtl/csb2cmac_arb_if.sv
// Bus bundle for the csb2cmac arbiter: two CSB request masters, the request path
// toward the csb2cmac retiming pipe, and the cmac2csb response fan-out.
interface csb2cmac_arb_if;
  logic        req0_pvld;
  logic        req0_prdy;
  logic [62:0] req0_pd;
  logic        req1_pvld;
  logic        req1_prdy;
  logic [62:0] req1_pd;
  logic        dst_pvld;
  logic        dst_prdy;
  logic [62:0] dst_pd;
  logic        resp_valid;
  logic [33:0] resp_pd;
  logic        resp0_valid;
  logic [33:0] resp0_pd;
  logic        resp1_valid;
  logic [33:0] resp1_pd;

  // Arbiter side: consumes both masters, drives the pipe and the returned responses.
  modport slave (
    input  req0_pvld, req0_pd, req1_pvld, req1_pd, dst_prdy, resp_valid, resp_pd,
    output req0_prdy, req1_prdy, dst_pvld, dst_pd, resp0_valid, resp0_pd,
    output resp1_valid, resp1_pd
  );

  // Environment side: the CSB masters, the retiming pipe and the cmac responder.
  modport master (
    output req0_pvld, req0_pd, req1_pvld, req1_pd, dst_prdy, resp_valid, resp_pd,
    input  req0_prdy, req1_prdy, dst_pvld, dst_pd, resp0_valid, resp0_pd,
    input  resp1_valid, resp1_pd
  );
endinterface

// File: rtl/csb2cmac_arb.sv
// Round-robin arbiter of two CSB masters onto csb2cmac, with an owner-tag FIFO that
// steers the in-order cmac2csb responses back to the master that issued each request.
module csb2cmac_arb #(
  parameter int MAX_OUTS = 4,
  parameter int CNT_W    = 3
) (
  input  logic             nvdla_core_clk,
  input  logic             nvdla_core_rstn,
  csb2cmac_arb_if.slave    bus,
  output logic [CNT_W-1:0] outs_cnt,
  output logic             err_unexp_resp
);
  localparam int               AW       = $clog2(MAX_OUTS);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_OUTS);

  logic             nr0, nr1;
  logic             not_full;
  logic             elig0, elig1;
  logic             grant0, grant1;
  logic             load_ok;
  logic             acc0, acc1, accept;
  logic             push, pop, head;
  logic [62:0]      sel_pd;

  logic             rr_last;  // 1: master 1 won the most recent accepted transfer
  logic             dst_vld_q;
  logic [62:0]      dst_pd_q;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0] cnt_q;
  logic             tag_mem [MAX_OUTS];
  logic             r0_vld_q, r1_vld_q, err_q;
  logic [33:0]      r0_pd_q, r1_pd_q;

  // A request expects a response unless it is a posted write.
  assign nr0 = ~bus.req0_pd[54] | bus.req0_pd[55];
  assign nr1 = ~bus.req1_pd[54] | bus.req1_pd[55];

  // Pre-pop occupancy: a response popping this cycle frees its slot only next cycle.
  assign not_full = (cnt_q != FULL_CNT);
  assign elig0    = bus.req0_pvld & (~nr0 | not_full);
  assign elig1    = bus.req1_pvld & (~nr1 | not_full);

  always_comb begin
    // NOTE: both outputs get a default before any branch, so no path can infer a latch.
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (elig0 && elig1) begin
      grant0 = rr_last;
      grant1 = ~rr_last;
    end else begin
      grant0 = elig0;
      grant1 = elig1;
    end
  end

  assign load_ok = ~dst_vld_q | bus.dst_prdy;
  assign acc0    = grant0 & load_ok;
  assign acc1    = grant1 & load_ok;
  assign accept  = acc0 | acc1;
  assign sel_pd  = acc1 ? bus.req1_pd : bus.req0_pd;
  assign push    = accept & (acc1 ? nr1 : nr0);
  assign pop     = bus.resp_valid & (cnt_q != '0);
  assign head    = tag_mem[rd_ptr];

  assign bus.req0_prdy   = acc0;
  assign bus.req1_prdy   = acc1;
  assign bus.dst_pvld    = dst_vld_q;
  assign bus.dst_pd      = dst_pd_q;
  assign bus.resp0_valid = r0_vld_q;
  assign bus.resp0_pd    = r0_pd_q;
  assign bus.resp1_valid = r1_vld_q;
  assign bus.resp1_pd    = r1_pd_q;
  assign outs_cnt        = cnt_q;
  assign err_unexp_resp  = err_q;

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      dst_vld_q <= 1'b0;
      rr_last   <= 1'b1;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt_q     <= '0;
      r0_vld_q  <= 1'b0;
      r1_vld_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking everywhere here, so every register samples pre-edge values.
      if (load_ok) dst_vld_q <= accept;
      if (accept)  rr_last   <= acc1;
      if (push)    wr_ptr    <= wr_ptr + AW'(1);
      if (pop)     rd_ptr    <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
      r0_vld_q <= pop & ~head;
      r1_vld_q <= pop & head;
      err_q    <= bus.resp_valid & (cnt_q == '0);
    end
  end

  // NOTE: tag slots and payloads carry no reset; they are only consumed when qualified
  // by the reset-cleared count or valid flags.
  always_ff @(posedge nvdla_core_clk) begin
    if (accept)          dst_pd_q        <= sel_pd;
    if (push)            tag_mem[wr_ptr] <= acc1;
    if (pop && !head)    r0_pd_q         <= bus.resp_pd;
    if (pop && head)     r1_pd_q         <= bus.resp_pd;
  end
endmodule

// File: tb/tb_csb2cmac_arb.sv
// Bench for csb2cmac_arb: directed scenarios plus a randomized run checked against a
// queue-based model of arbitration, output staging and response routing.
module tb_csb2cmac_arb;
  localparam int MAX_OUTS = 4;
  localparam int CNT_W    = 3;

  logic             nvdla_core_clk = 1'b0;
  logic             nvdla_core_rstn;
  logic [CNT_W-1:0] outs_cnt;
  logic             err_unexp_resp;
  int               checks   = 0;
  int               failures = 0;

  csb2cmac_arb_if bus ();

  csb2cmac_arb #(.MAX_OUTS(MAX_OUTS), .CNT_W(CNT_W)) dut (
    .nvdla_core_clk (nvdla_core_clk),
    .nvdla_core_rstn(nvdla_core_rstn),
    .bus            (bus),
    .outs_cnt       (outs_cnt),
    .err_unexp_resp (err_unexp_resp)
  );

  always #5 nvdla_core_clk = ~nvdla_core_clk;

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge nvdla_core_clk);
    #2;
  endtask

  function automatic logic [62:0] mk_pd(input logic [21:0] addr, input logic wr, input logic np);
    logic [62:0] pd;
    pd        = 63'({$urandom(), $urandom()});
    pd[21:0]  = addr;
    pd[54]    = wr;
    pd[55]    = np;
    return pd;
  endfunction

  function automatic bit needs_resp(input logic [62:0] pd);
    return (pd[54] == 1'b0) || (pd[55] == 1'b1);
  endfunction

  task automatic idle_inputs();
    bus.req0_pvld  = 1'b0;
    bus.req0_pd    = '0;
    bus.req1_pvld  = 1'b0;
    bus.req1_pd    = '0;
    bus.dst_prdy   = 1'b1;
    bus.resp_valid = 1'b0;
    bus.resp_pd    = '0;
  endtask

  task automatic test_reset();
    nvdla_core_rstn = 1'b0;
    idle_inputs();
    #12;
    checks++; if (bus.dst_pvld !== 1'b0) begin failures++; $display("FAIL rst_dst_pvld got=%0b exp=0", bus.dst_pvld); end
    checks++; if (bus.resp0_valid !== 1'b0 || bus.resp1_valid !== 1'b0) begin failures++; $display("FAIL rst_resp_valid got=%0b%0b exp=00", bus.resp0_valid, bus.resp1_valid); end
    checks++; if (outs_cnt !== 3'd0) begin failures++; $display("FAIL rst_outs_cnt got=%0d exp=0", outs_cnt); end
    checks++; if (err_unexp_resp !== 1'b0) begin failures++; $display("FAIL rst_err got=%0b exp=0", err_unexp_resp); end
    @(negedge nvdla_core_clk);
    nvdla_core_rstn = 1'b1;
    cyc();
  endtask

  // Both masters request reads every cycle; grants alternate starting at master 0.
  task automatic test_round_robin();
    logic [62:0] pd0, pd1;
    int g, owner;
    pd0 = mk_pd(22'h10, 1'b0, 1'b0);
    pd1 = mk_pd(22'h20, 1'b0, 1'b0);
    bus.req0_pd = pd0;
    bus.req1_pd = pd1;
    for (int k = 0; k < 5; k++) begin
      bus.req0_pvld  = (k < 4);
      bus.req1_pvld  = (k < 4);
      bus.resp_valid = (k > 0);
      bus.resp_pd    = 34'(k);
      g = k % 2;
      if (k < 4) begin
        #1;
        checks++; if (bus.req0_prdy !== (g == 0) || bus.req1_prdy !== (g == 1)) begin failures++; $display("FAIL rr_prdy k=%0d got=%0b%0b exp_grant=%0d", k, bus.req0_prdy, bus.req1_prdy, g); end
      end
      cyc();
      if (k < 4) begin
        checks++; if (bus.dst_pvld !== 1'b1 || bus.dst_pd !== (g == 0 ? pd0 : pd1)) begin failures++; $display("FAIL rr_dst k=%0d got=%0h exp=%0h", k, bus.dst_pd, (g == 0 ? pd0 : pd1)); end
      end
      if (k > 0) begin
        owner = (k - 1) % 2;
        checks++; if (bus.resp0_valid !== (owner == 0) || bus.resp1_valid !== (owner == 1)) begin failures++; $display("FAIL rr_route k=%0d got=%0b%0b exp_owner=%0d", k, bus.resp0_valid, bus.resp1_valid, owner); end
        checks++; if ((owner == 0 ? bus.resp0_pd : bus.resp1_pd) !== 34'(k)) begin failures++; $display("FAIL rr_resp_pd k=%0d got=%0h exp=%0h", k, (owner == 0 ? bus.resp0_pd : bus.resp1_pd), k); end
      end
      checks++; if (outs_cnt !== (k < 4 ? 3'd1 : 3'd0)) begin failures++; $display("FAIL rr_outs k=%0d got=%0d exp=%0d", k, outs_cnt, (k < 4 ? 1 : 0)); end
    end
    idle_inputs();
    cyc();
  endtask

  task automatic test_single_read();
    logic [62:0] pd;
    pd = mk_pd(22'h00100, 1'b0, 1'b0);
    bus.req0_pvld = 1'b1;
    bus.req0_pd   = pd;
    #1;
    checks++; if (bus.req0_prdy !== 1'b1 || bus.req1_prdy !== 1'b0) begin failures++; $display("FAIL sr_prdy got=%0b%0b exp=10", bus.req0_prdy, bus.req1_prdy); end
    cyc();
    bus.req0_pvld = 1'b0;
    checks++; if (bus.dst_pvld !== 1'b1 || bus.dst_pd !== pd) begin failures++; $display("FAIL sr_dst got=%0b/%0h exp=1/%0h", bus.dst_pvld, bus.dst_pd, pd); end
    checks++; if (outs_cnt !== 3'd1) begin failures++; $display("FAIL sr_outs1 got=%0d exp=1", outs_cnt); end
    bus.resp_valid = 1'b1;
    bus.resp_pd    = 34'h0_DEADBEEF;
    cyc();
    bus.resp_valid = 1'b0;
    checks++; if (bus.resp0_valid !== 1'b1 || bus.resp0_pd !== 34'h0_DEADBEEF) begin failures++; $display("FAIL sr_resp0 got=%0b/%0h exp=1/deadbeef", bus.resp0_valid, bus.resp0_pd); end
    checks++; if (bus.resp1_valid !== 1'b0) begin failures++; $display("FAIL sr_resp1 got=%0b exp=0", bus.resp1_valid); end
    checks++; if (outs_cnt !== 3'd0) begin failures++; $display("FAIL sr_outs0 got=%0d exp=0", outs_cnt); end
    cyc();
    checks++; if (bus.resp0_valid !== 1'b0) begin failures++; $display("FAIL sr_pulse got=%0b exp=0", bus.resp0_valid); end
  endtask

  task automatic test_full_stall();
    logic [62:0] pd5, pdw;
    for (int i = 0; i < 4; i++) begin
      bus.req0_pvld = 1'b1;
      bus.req0_pd   = mk_pd(22'(22'h200 + i), 1'b0, 1'b0);
      cyc();
    end
    pd5 = mk_pd(22'h300, 1'b0, 1'b0);
    pdw = mk_pd(22'h310, 1'b1, 1'b0);
    bus.req0_pd   = pd5;
    bus.req1_pvld = 1'b1;
    bus.req1_pd   = pdw;
    #1;
    checks++; if (outs_cnt !== 3'd4) begin failures++; $display("FAIL fs_outs4 got=%0d exp=4", outs_cnt); end
    checks++; if (bus.req0_prdy !== 1'b0 || bus.req1_prdy !== 1'b1) begin failures++; $display("FAIL fs_posted_prdy got=%0b%0b exp=01", bus.req0_prdy, bus.req1_prdy); end
    cyc();
    bus.req1_pvld = 1'b0;
    checks++; if (bus.dst_pd !== pdw || outs_cnt !== 3'd4) begin failures++; $display("FAIL fs_posted got=%0h/%0d exp=%0h/4", bus.dst_pd, outs_cnt, pdw); end
    bus.resp_valid = 1'b1;
    bus.resp_pd    = 34'h1;
    #1;
    checks++; if (bus.req0_prdy !== 1'b0) begin failures++; $display("FAIL fs_prepop got=%0b exp=0", bus.req0_prdy); end
    cyc();
    bus.resp_valid = 1'b0;
    checks++; if (bus.resp0_valid !== 1'b1 || outs_cnt !== 3'd3) begin failures++; $display("FAIL fs_pop got=%0b/%0d exp=1/3", bus.resp0_valid, outs_cnt); end
    #1;
    checks++; if (bus.req0_prdy !== 1'b1) begin failures++; $display("FAIL fs_resume got=%0b exp=1", bus.req0_prdy); end
    cyc();
    bus.req0_pvld = 1'b0;
    checks++; if (bus.dst_pd !== pd5 || outs_cnt !== 3'd4) begin failures++; $display("FAIL fs_fifth got=%0h/%0d exp=%0h/4", bus.dst_pd, outs_cnt, pd5); end
    bus.resp_valid = 1'b1;
    repeat (4) cyc();
    bus.resp_valid = 1'b0;
    checks++; if (outs_cnt !== 3'd0) begin failures++; $display("FAIL fs_drain got=%0d exp=0", outs_cnt); end
    cyc();
  endtask

  task automatic test_backpressure();
    logic [62:0] pda, pdb, pdc;
    pda = mk_pd(22'h400, 1'b1, 1'b0);
    pdb = mk_pd(22'h401, 1'b1, 1'b0);
    pdc = mk_pd(22'h402, 1'b1, 1'b0);
    bus.req0_pvld = 1'b1;
    bus.req0_pd   = pda;
    cyc();
    bus.dst_prdy  = 1'b0;
    bus.req0_pd   = pdb;
    bus.req1_pvld = 1'b1;
    bus.req1_pd   = pdc;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (bus.req0_prdy !== 1'b0 || bus.req1_prdy !== 1'b0) begin failures++; $display("FAIL bp_prdy i=%0d got=%0b%0b exp=00", i, bus.req0_prdy, bus.req1_prdy); end
      cyc();
      checks++; if (bus.dst_pvld !== 1'b1 || bus.dst_pd !== pda) begin failures++; $display("FAIL bp_hold i=%0d got=%0h exp=%0h", i, bus.dst_pd, pda); end
    end
    bus.dst_prdy = 1'b1;
    #1;
    checks++; if (bus.req0_prdy !== 1'b0 || bus.req1_prdy !== 1'b1) begin failures++; $display("FAIL bp_release got=%0b%0b exp=01", bus.req0_prdy, bus.req1_prdy); end
    cyc();
    bus.req1_pvld = 1'b0;
    checks++; if (bus.dst_pd !== pdc) begin failures++; $display("FAIL bp_next got=%0h exp=%0h", bus.dst_pd, pdc); end
    cyc();
    bus.req0_pvld = 1'b0;
    checks++; if (bus.dst_pvld !== 1'b1 || bus.dst_pd !== pdb) begin failures++; $display("FAIL bp_last got=%0h exp=%0h", bus.dst_pd, pdb); end
    cyc();
    checks++; if (bus.dst_pvld !== 1'b0) begin failures++; $display("FAIL bp_empty got=%0b exp=0", bus.dst_pvld); end
  endtask

  task automatic test_unexpected();
    bus.resp_valid = 1'b1;
    bus.resp_pd    = 34'h3_0000_0001;
    cyc();
    bus.resp_valid = 1'b0;
    checks++; if (err_unexp_resp !== 1'b1 || bus.resp0_valid !== 1'b0 || bus.resp1_valid !== 1'b0 || outs_cnt !== 3'd0) begin failures++; $display("FAIL ur_flag got=%0b%0b%0b/%0d exp=100/0", err_unexp_resp, bus.resp0_valid, bus.resp1_valid, outs_cnt); end
    cyc();
    checks++; if (err_unexp_resp !== 1'b0) begin failures++; $display("FAIL ur_pulse got=%0b exp=0", err_unexp_resp); end
    // Response on an empty FIFO in the same cycle as a push is still unexpected.
    bus.req0_pvld  = 1'b1;
    bus.req0_pd    = mk_pd(22'h500, 1'b0, 1'b0);
    bus.resp_valid = 1'b1;
    cyc();
    bus.req0_pvld  = 1'b0;
    checks++; if (err_unexp_resp !== 1'b1 || bus.resp0_valid !== 1'b0 || outs_cnt !== 3'd1) begin failures++; $display("FAIL ur_push got=%0b%0b/%0d exp=10/1", err_unexp_resp, bus.resp0_valid, outs_cnt); end
    bus.resp_pd = 34'h2_AAAA_5555;
    cyc();
    bus.resp_valid = 1'b0;
    checks++; if (err_unexp_resp !== 1'b0 || bus.resp0_valid !== 1'b1 || bus.resp0_pd !== 34'h2_AAAA_5555 || outs_cnt !== 3'd0) begin failures++; $display("FAIL ur_after got=%0b%0b/%0h/%0d exp=01/2aaaa5555/0", err_unexp_resp, bus.resp0_valid, bus.resp0_pd, outs_cnt); end
    cyc();
  endtask

  task automatic test_async_reset();
    bus.req0_pvld = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.req0_pd = mk_pd(22'(22'h600 + i), 1'b0, 1'b0);
      cyc();
    end
    bus.req0_pvld = 1'b0;
    checks++; if (outs_cnt !== 3'd3 || bus.dst_pvld !== 1'b1) begin failures++; $display("FAIL ar_pre got=%0d/%0b exp=3/1", outs_cnt, bus.dst_pvld); end
    #2;
    nvdla_core_rstn = 1'b0;
    #1;
    checks++; if (bus.dst_pvld !== 1'b0 || outs_cnt !== 3'd0) begin failures++; $display("FAIL ar_flush got=%0b/%0d exp=0/0", bus.dst_pvld, outs_cnt); end
    #2;
    nvdla_core_rstn = 1'b1;
    cyc();
    bus.resp_valid = 1'b1;
    cyc();
    bus.resp_valid = 1'b0;
    checks++; if (err_unexp_resp !== 1'b1 || bus.resp0_valid !== 1'b0 || bus.resp1_valid !== 1'b0) begin failures++; $display("FAIL ar_unexp got=%0b%0b%0b exp=100", err_unexp_resp, bus.resp0_valid, bus.resp1_valid); end
    cyc();
  endtask

  // Random traffic against a model: owner queue, a one-entry output stage, last winner.
  task automatic test_random();
    bit          m_dst_v, m_r0v, m_r1v, m_err;
    logic [62:0] m_dst_pd;
    logic [33:0] m_r0pd, m_r1pd;
    int          m_q[$];
    int          m_last, cnt, g, own;
    bit          v0, v1, rv, dprdy, e0, e1, room;
    logic [62:0] pd0, pd1;
    logic [33:0] rpd;
    idle_inputs();
    @(negedge nvdla_core_clk);
    nvdla_core_rstn = 1'b0;
    #2;
    nvdla_core_rstn = 1'b1;
    m_dst_v = 1'b0; m_r0pd = '0; m_r1pd = '0; m_dst_pd = '0;
    m_q.delete();
    m_last = 1;
    cyc();
    for (int i = 0; i < 600; i++) begin
      v0    = 1'($urandom_range(0, 1));
      v1    = 1'($urandom_range(0, 1));
      pd0   = mk_pd(22'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      pd1   = mk_pd(22'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      rv    = ($urandom_range(0, 3) == 0);
      rpd   = 34'({$urandom(), $urandom()});
      dprdy = ($urandom_range(0, 3) != 0);
      bus.req0_pvld = v0; bus.req0_pd = pd0;
      bus.req1_pvld = v1; bus.req1_pd = pd1;
      bus.resp_valid = rv; bus.resp_pd = rpd;
      bus.dst_prdy = dprdy;
      #1;
      cnt  = m_q.size();
      e0   = v0 && (!needs_resp(pd0) || cnt < MAX_OUTS);
      e1   = v1 && (!needs_resp(pd1) || cnt < MAX_OUTS);
      g    = -1;
      if (e0 && e1) g = (m_last == 0) ? 1 : 0;
      else if (e0)  g = 0;
      else if (e1)  g = 1;
      room = !m_dst_v || dprdy;
      checks++; if (bus.req0_prdy !== ((g == 0) && room) || bus.req1_prdy !== ((g == 1) && room)) begin failures++; $display("FAIL rnd_prdy i=%0d got=%0b%0b exp=%0b%0b", i, bus.req0_prdy, bus.req1_prdy, (g == 0) && room, (g == 1) && room); end
      m_err = rv && (cnt == 0);
      m_r0v = 1'b0;
      m_r1v = 1'b0;
      if (rv && cnt > 0) begin
        own = m_q.pop_front();
        if (own == 0) begin m_r0v = 1'b1; m_r0pd = rpd; end
        else          begin m_r1v = 1'b1; m_r1pd = rpd; end
      end
      if (room) begin
        m_dst_v = (g >= 0);
        if (g >= 0) begin
          m_dst_pd = (g == 0) ? pd0 : pd1;
          m_last   = g;
          if (needs_resp(m_dst_pd)) m_q.push_back(g);
        end
      end
      cyc();
      checks++; if (bus.dst_pvld !== m_dst_v || (m_dst_v && bus.dst_pd !== m_dst_pd)) begin failures++; $display("FAIL rnd_dst i=%0d got=%0b/%0h exp=%0b/%0h", i, bus.dst_pvld, bus.dst_pd, m_dst_v, m_dst_pd); end
      checks++; if (bus.resp0_valid !== m_r0v || (m_r0v && bus.resp0_pd !== m_r0pd)) begin failures++; $display("FAIL rnd_resp0 i=%0d got=%0b/%0h exp=%0b/%0h", i, bus.resp0_valid, bus.resp0_pd, m_r0v, m_r0pd); end
      checks++; if (bus.resp1_valid !== m_r1v || (m_r1v && bus.resp1_pd !== m_r1pd)) begin failures++; $display("FAIL rnd_resp1 i=%0d got=%0b/%0h exp=%0b/%0h", i, bus.resp1_valid, bus.resp1_pd, m_r1v, m_r1pd); end
      checks++; if (outs_cnt !== CNT_W'(m_q.size()) || err_unexp_resp !== m_err) begin failures++; $display("FAIL rnd_cnt_err i=%0d got=%0d/%0b exp=%0d/%0b", i, outs_cnt, err_unexp_resp, m_q.size(), m_err); end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single_read();
    test_full_stall();
    test_backpressure();
    test_unexpected();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/csb2cmac_arb.md
Name: csb2cmac_arb

Overview:
- Arbitrates two CSB masters (req0 = primary CSB master, req1 = debug/secondary master) onto the single csb2cmac request channel, upstream of the csb2cmac retiming pipe.
- Tracks which master owns each response-expecting request and routes the in-order cmac2csb responses back to that master.
- Limits outstanding response-expecting requests to a parameterised depth.

Parameters:
- MAX_OUTS, 4, maximum outstanding response-expecting requests; tag FIFO depth (power of 2, 2..16).
- CNT_W, 3, width of the outstanding counter; equals log2(MAX_OUTS)+1.

Ports:
- nvdla_core_clk  in  1  core clock
- nvdla_core_rstn  in  1  asynchronous active-low reset
- req0_pvld  in  1  master 0 request valid
- req0_prdy  out  1  master 0 request ready
- req0_pd  in  63  master 0 request: addr[21:0], wdat[53:22], write[54], nposted[55], srcpriv[56], wrbe[60:57], level[62:61]
- req1_pvld  in  1  master 1 request valid
- req1_prdy  out  1  master 1 request ready
- req1_pd  in  63  master 1 request, same format as req0_pd
- dst_pvld  out  1  request valid toward the retiming pipe
- dst_prdy  in  1  downstream ready
- dst_pd  out  63  forwarded request
- resp_valid  in  1  cmac response valid; no backpressure
- resp_pd  in  34  cmac response
- resp0_valid  out  1  response to master 0
- resp0_pd  out  34  response payload to master 0
- resp1_valid  out  1  response to master 1
- resp1_pd  out  34  response payload to master 1
- outs_cnt  out  CNT_W  current outstanding count
- err_unexp_resp  out  1  one-cycle pulse when a response arrives with no tag

Behaviour:
- Clock and reset: one clock, nvdla_core_clk; reset nvdla_core_rstn is asynchronous, active-low.
- Reset values: dst_pvld=0, resp0_valid=0, resp1_valid=0, outs_cnt=0, err_unexp_resp=0, tag FIFO empty, RR pointer = master 0 preferred. Payload registers are not reset.
- Response-expecting request (needs_resp): write==0, or nposted==1. Posted writes (write=1, nposted=0) need no response.
- Output stage: one register. Loads when empty or dst_prdy=1. dst_pvld holds until dst_prdy. dst_pd stays stable while dst_pvld=1 and dst_prdy=0. Request latency: accept to dst_pvld is 1 cycle.
- Eligibility: reqN is eligible when reqN_pvld=1, and either it is a posted write or outs_cnt < MAX_OUTS.
- Arbitration is round-robin between eligible masters.
  - If only one master is eligible, it is granted.
  - If both are eligible, the master not granted last is granted.
  - The pointer updates only on an accepted transfer.
- Ready: reqN_prdy = grantN & (out_reg empty | dst_prdy). At most one prdy is high per cycle. Grant is combinational from pvld/pd; no combinational path from pd to prdy other than the needs_resp decode.
- Tag FIFO: on an accepted needs_resp request, push the master id (0/1). On resp_valid, pop the head and route.
  - resp_pd is registered into respN_pd; respN_valid pulses 1 cycle later. The other master's valid stays 0.
- Counter: outs_cnt = FIFO occupancy.
  - Push only: +1. Pop only: -1. Push and pop in the same cycle: unchanged. The FIFO must handle simultaneous push/pop when full; the pop frees the slot, but eligibility uses the pre-pop count.
- Unexpected response: resp_valid with the FIFO empty (pre-push state, even if a push occurs in the same cycle).
  - The response is dropped: no respN_valid.
  - err_unexp_resp=1 for one cycle. The FIFO and counter are unaffected.
- Full: when outs_cnt==MAX_OUTS, needs_resp requests stall (prdy=0). Posted writes from either master still flow. A stalled needs_resp master does not block the other master's posted write.
- Wrap-around: FIFO read/write pointers wrap modulo MAX_OUTS. Use an extra bit or the counter to distinguish full from empty.
- Reset mid-operation: all in-flight state is discarded: output register invalid, FIFO flushed, counter 0. Responses arriving after reset are flagged unexpected.

Test Plan:
- Single master read: req0 read (write=0) of addr 0x00100 with dst_prdy=1 -> dst_pvld 1 cycle later with identical pd, outs_cnt=1. Then resp_valid with resp_pd=0x0_DEADBEEF -> resp0_valid pulses next cycle with that pd, resp1_valid=0, outs_cnt=0.
- Round-robin fairness: both masters hold reads continuously, dst_prdy=1, responses returned promptly -> dst order 0,1,0,1. Responses delivered to masters in matching order.
- Full stall: MAX_OUTS=4, issue 4 reads with no responses -> outs_cnt=4 and a 5th read gets prdy=0. A posted write from req1 is still accepted. Then a resp_valid pulse -> 5th read accepted within 1 cycle, outs_cnt remains 4.
- Backpressure: dst_prdy=0 for 5 cycles with dst_pvld=1 -> dst_pd stable and both prdy=0. When dst_prdy=1, the next grant loads in the same cycle, with no loss or duplication.
- Unexpected response: resp_valid with outs_cnt=0 -> err_unexp_resp high exactly 1 cycle, no respN_valid, outs_cnt stays 0.
- Async reset mid-flight: 3 outstanding reads, then assert nvdla_core_rstn=0 mid-cycle -> dst_pvld=0 and outs_cnt=0 immediately. After release, the first response raises err_unexp_resp.
